// File: rtl/uart_frame_codec.sv
// Delimiter-framed byte codec: TX framer and RX deframer sharing one clock.
// Optional checksum byte enabled by defining UART_FRAME_CHECKSUM_EN.
module uart_frame_codec #(
  parameter int          MAX_LEN     = 64,
  parameter logic [7:0]  DELIM       = 8'h26,
  parameter int          TIMEOUT_CLK = 50_000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [MAX_LEN*8-1:0] tx_string,
  input  logic [7:0]           tx_length,
  input  logic                 tx_req,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [MAX_LEN*8-1:0] rx_string,
  output logic [7:0]           rx_length,
  output logic                 rx_busy,
  output logic                 rx_done,
  output logic                 rx_err,
  output logic [7:0]           byte_tx_data,
  output logic                 byte_tx_req,
  input  logic                 byte_tx_done,
  input  logic [7:0]           byte_rx_data,
  input  logic                 byte_rx_vld
);

`ifdef UART_FRAME_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int SHW = MAX_LEN + CS;
  localparam int TW  = $clog2(TIMEOUT_CLK + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLK - 1);

  typedef enum logic [2:0] {
    T_IDLE, T_HEAD, T_BODY, T_CSUM, T_TAIL, T_DONE
  } tx_st_e;

  typedef enum logic [1:0] {
    R_IDLE, R_H1, R_BODY, R_E1
  } rx_st_e;

  tx_st_e               r_tx_st;
  tx_st_e               w_tx_nxt;
  tx_st_e               w_post;
  logic [MAX_LEN*8-1:0] r_tx_buf;
  logic [7:0]           r_tx_rem;
  logic                 r_tx_sub;
  logic [7:0]           r_tx_csum;
  logic [7:0]           w_post_dat;
  logic                 w_issue;
  logic [7:0]           w_dat;
  logic                 w_shift;
  logic                 w_accept;

  assign w_post     = (CS != 0) ? T_CSUM : T_TAIL;
  assign w_post_dat = (CS != 0) ? r_tx_csum : DELIM;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_tx_st <= T_IDLE;
    else            r_tx_st <= w_tx_nxt;
  end

  always_comb begin
    w_tx_nxt = r_tx_st;
    w_issue  = 1'b0;
    w_dat    = DELIM;
    w_shift  = 1'b0;
    w_accept = 1'b0;
    unique case (r_tx_st)
      T_IDLE: if (tx_req) begin
        w_accept = 1'b1;
        w_issue  = 1'b1;
        w_tx_nxt = T_HEAD;
      end
      T_HEAD: if (byte_tx_done) begin
        w_issue = 1'b1;
        if (r_tx_sub) begin
          if (r_tx_rem != 8'd0) begin
            w_dat    = r_tx_buf[7:0];
            w_shift  = 1'b1;
            w_tx_nxt = T_BODY;
          end else begin
            w_dat    = w_post_dat;
            w_tx_nxt = w_post;
          end
        end
      end
      T_BODY: if (byte_tx_done) begin
        w_issue = 1'b1;
        if (r_tx_rem != 8'd0) begin
          w_dat   = r_tx_buf[7:0];
          w_shift = 1'b1;
        end else begin
          w_dat    = w_post_dat;
          w_tx_nxt = w_post;
        end
      end
      T_CSUM: if (byte_tx_done) begin
        w_issue  = 1'b1;
        w_tx_nxt = T_TAIL;
      end
      T_TAIL: if (byte_tx_done) begin
        if (r_tx_sub) w_tx_nxt = T_DONE;
        else          w_issue  = 1'b1;
      end
      T_DONE:  w_tx_nxt = T_IDLE;
      default: w_tx_nxt = T_IDLE;
    endcase
  end

  always_comb begin
    tx_busy      = (r_tx_st != T_IDLE);
    tx_done      = (r_tx_st == T_DONE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tx_buf     <= '0;
      r_tx_rem     <= '0;
      r_tx_sub     <= 1'b0;
      r_tx_csum    <= '0;
      byte_tx_req  <= 1'b0;
      byte_tx_data <= '0;
    end else begin
      byte_tx_req <= w_issue;
      if (w_issue) byte_tx_data <= w_dat;
      if (w_accept) begin
        r_tx_buf  <= tx_string;
        r_tx_rem  <= (tx_length > 8'(MAX_LEN)) ? 8'(MAX_LEN) : tx_length;
        r_tx_csum <= '0;
        r_tx_sub  <= 1'b0;
      end else begin
        if (w_shift) begin
          r_tx_buf  <= r_tx_buf >> 8;
          r_tx_rem  <= r_tx_rem - 8'd1;
          r_tx_csum <= r_tx_csum ^ r_tx_buf[7:0];
        end
        // second delimiter of head/tail is tracked by r_tx_sub
        if (byte_tx_done && !r_tx_sub &&
            (r_tx_st == T_HEAD || r_tx_st == T_TAIL))
          r_tx_sub <= 1'b1;
        else if (w_tx_nxt == T_TAIL && r_tx_st != T_TAIL)
          r_tx_sub <= 1'b0;
      end
    end
  end

  rx_st_e           r_rx_st;
  rx_st_e           w_rx_nxt;
  logic [SHW*8-1:0] r_shadow;
  logic [9:0]       r_cnt;
  logic [7:0]       r_x;
  logic [TW-1:0]    r_tmr;
  logic [9:0]       w_rx_len;
  logic             w_dlm;
  logic             w_done;
  logic             w_err;
  logic             w_clr;
  logic             w_st1;
  logic             w_st2;

  assign w_rx_len = r_cnt - 10'(CS);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_rx_st <= R_IDLE;
    else            r_rx_st <= w_rx_nxt;
  end

  always_comb begin
    w_rx_nxt = r_rx_st;
    w_done   = 1'b0;
    w_err    = 1'b0;
    w_clr    = 1'b0;
    w_st1    = 1'b0;
    w_st2    = 1'b0;
    w_dlm    = (byte_rx_data == DELIM);
    if (r_rx_st != R_IDLE && !byte_rx_vld && r_tmr == TMAX) begin
      w_err    = 1'b1;
      w_rx_nxt = R_IDLE;
    end else if (byte_rx_vld) begin
      unique case (r_rx_st)
        R_IDLE: if (w_dlm) w_rx_nxt = R_H1;
        R_H1: begin
          w_rx_nxt = w_dlm ? R_BODY : R_IDLE;
          w_clr    = w_dlm;
        end
        R_BODY: begin
          if (w_dlm) begin
            w_rx_nxt = R_E1;
          end else if (r_cnt >= 10'(SHW)) begin
            w_err    = 1'b1;
            w_rx_nxt = R_IDLE;
          end else begin
            w_st1 = 1'b1;
          end
        end
        R_E1: begin
          if (w_dlm) begin
            w_rx_nxt = R_IDLE;
            if (CS != 0 && (r_cnt == 10'd0 || r_x != 8'd0))
              w_err = 1'b1;
            else
              w_done = 1'b1;
          end else if (r_cnt + 10'd2 > 10'(SHW)) begin
            w_err    = 1'b1;
            w_rx_nxt = R_IDLE;
          end else begin
            w_st2    = 1'b1;
            w_rx_nxt = R_BODY;
          end
        end
        default: w_rx_nxt = R_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_busy = (r_rx_st != R_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_shadow  <= '0;
      r_cnt     <= '0;
      r_x       <= '0;
      r_tmr     <= '0;
      rx_done   <= 1'b0;
      rx_err    <= 1'b0;
      rx_string <= '0;
      rx_length <= '0;
    end else begin
      rx_done <= w_done;
      rx_err  <= w_err;
      if (r_rx_st == R_IDLE || byte_rx_vld) r_tmr <= '0;
      else if (r_tmr != TMAX)               r_tmr <= r_tmr + 1'b1;
      if (w_clr) begin
        r_cnt    <= '0;
        r_x      <= '0;
        r_shadow <= '0;
      end
      if (w_st1) begin
        r_cnt <= r_cnt + 10'd1;
        r_x   <= r_x ^ byte_rx_data;
      end
      if (w_st2) begin
        r_cnt <= r_cnt + 10'd2;
        r_x   <= r_x ^ byte_rx_data ^ DELIM;
      end
      // an escaped delimiter lands as two payload bytes
      for (int k = 0; k < SHW; k++) begin
        if (w_st1 && r_cnt == 10'(k))
          r_shadow[k*8 +: 8] <= byte_rx_data;
        if (w_st2 && r_cnt == 10'(k))
          r_shadow[k*8 +: 8] <= DELIM;
        if (w_st2 && r_cnt + 10'd1 == 10'(k))
          r_shadow[k*8 +: 8] <= byte_rx_data;
      end
      if (w_done) begin
        rx_length <= w_rx_len[7:0];
        for (int k = 0; k < MAX_LEN; k++)
          rx_string[k*8 +: 8] <=
            (10'(k) < w_rx_len) ? r_shadow[k*8 +: 8] : 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_codec.sv
// Directed bench for uart_frame_codec: TX byte order, RX framing,
// overflow, timeout and mid-frame reset.
module tb_uart_frame_codec;

  localparam int ML = 8;
  localparam int TO = 200;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [ML*8-1:0] tx_string = '0;
  logic [7:0]    tx_length = '0;
  logic          tx_req = 1'b0;
  logic          tx_busy, tx_done;
  logic [ML*8-1:0] rx_string;
  logic [7:0]    rx_length;
  logic          rx_busy, rx_done, rx_err;
  logic [7:0]    byte_tx_data;
  logic          byte_tx_req;
  logic          byte_tx_done = 1'b0;
  logic [7:0]    byte_rx_data = '0;
  logic          byte_rx_vld = 1'b0;

  always #5 sys_clk = ~sys_clk;

  uart_frame_codec #(
    .MAX_LEN(ML), .DELIM(8'h26), .TIMEOUT_CLK(TO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .tx_string(tx_string), .tx_length(tx_length),
    .tx_req(tx_req), .tx_busy(tx_busy), .tx_done(tx_done),
    .rx_string(rx_string), .rx_length(rx_length),
    .rx_busy(rx_busy), .rx_done(rx_done), .rx_err(rx_err),
    .byte_tx_data(byte_tx_data), .byte_tx_req(byte_tx_req),
    .byte_tx_done(byte_tx_done),
    .byte_rx_data(byte_rx_data), .byte_rx_vld(byte_rx_vld)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_txd = 0;
  int n_rxd = 0;
  int n_rxe = 0;
  logic [7:0] cap[$];
  logic [7:0] expq[$];
  logic [7:0] rxq[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (tx_done) n_txd++;
    if (rx_done) n_rxd++;
    if (rx_err)  n_rxe++;
  end

  // byte-level transmitter model: done ~10 cycles after each request
  initial forever begin
    @(negedge sys_clk);
    byte_tx_done = 1'b0;
    if (byte_tx_req === 1'b1) begin
      cap.push_back(byte_tx_data);
      repeat (9) @(negedge sys_clk);
      byte_tx_done = 1'b1;
    end
  end

  task automatic tx_run(input string tag,
                        input logic [63:0] s,
                        input logic [7:0] len);
    int t;
    int n0;
    cap.delete();
    n0 = n_txd;
    @(negedge sys_clk);
    tx_string = s;
    tx_length = len;
    tx_req = 1'b1;
    @(negedge sys_clk);
    chk({tag, "_busy"}, tx_busy, 1'b1);
    chk({tag, "_req"}, byte_tx_req, 1'b1);
    chk({tag, "_d0"}, byte_tx_data, 8'h26);
    tx_string = 64'hEEEE_EEEE_EEEE_EEEE;
    tx_length = 8'd5;
    @(negedge sys_clk);
    tx_req = 1'b0;
    t = 0;
    while (tx_busy && t < 3000) begin
      @(negedge sys_clk);
      t++;
    end
    chk({tag, "_tmo"}, t < 3000, 1'b1);
    repeat (2) @(negedge sys_clk);
    chk({tag, "_txdone"}, n_txd - n0, 1);
    chk({tag, "_nbytes"}, cap.size(), expq.size());
    for (int i = 0; i < expq.size() && i < cap.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), cap[i], expq[i]);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge sys_clk);
    byte_rx_data = b;
    byte_rx_vld = 1'b1;
    @(negedge sys_clk);
    byte_rx_vld = 1'b0;
  endtask

  task automatic rx_run(input string tag, input logic ok,
                        input logic [7:0] elen,
                        input logic [63:0] estr);
    int d0, e0;
    logic [7:0] pl;
    logic [63:0] ps;
    d0 = n_rxd;
    e0 = n_rxe;
    pl = rx_length;
    ps = rx_string;
    foreach (rxq[i]) rx_byte(rxq[i]);
    repeat (3) @(negedge sys_clk);
    chk({tag, "_done"}, n_rxd - d0, ok ? 1 : 0);
    chk({tag, "_err"}, n_rxe - e0, ok ? 0 : 1);
    chk({tag, "_len"}, rx_length, ok ? elen : pl);
    chk({tag, "_str"}, rx_string, ok ? estr : ps);
    chk({tag, "_busy"}, rx_busy, 1'b0);
  endtask

  initial begin
    int d0, e0, t0;
    repeat (3) @(negedge sys_clk);
    chk("rst_txbusy", tx_busy, 1'b0);
    chk("rst_rxbusy", rx_busy, 1'b0);
    chk("rst_btxreq", byte_tx_req, 1'b0);
    chk("rst_btxdat", byte_tx_data, 8'h00);
    chk("rst_rxlen", rx_length, 8'h00);
    chk("rst_rxstr", rx_string, 64'h0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    expq = '{8'h26, 8'h26, 8'h41, 8'h42, 8'h43};
    if (CS) expq.push_back(8'h40);
    expq.push_back(8'h26);
    expq.push_back(8'h26);
    tx_run("tx_abc", 64'h434241, 8'd3);

    expq = '{8'h26, 8'h26};
    if (CS) expq.push_back(8'h00);
    expq.push_back(8'h26);
    expq.push_back(8'h26);
    tx_run("tx_n0", 64'h0, 8'd0);

    expq = '{8'h26, 8'h26, 8'h41, 8'h42};
    if (CS) expq.push_back(8'h03);
    expq.push_back(8'h26);
    expq.push_back(8'h26);
    tx_run("tx_ab", 64'h4241, 8'd2);

    expq = '{8'h26, 8'h26, 8'h31, 8'h32, 8'h33, 8'h34,
             8'h35, 8'h36, 8'h37, 8'h38};
    if (CS) expq.push_back(8'h08);
    expq.push_back(8'h26);
    expq.push_back(8'h26);
    tx_run("tx_clamp", 64'h3837363534333231, 8'd20);

    rxq = '{8'h26, 8'h26, 8'h48, 8'h69, 8'h26, 8'h26};
`ifdef UART_FRAME_CHECKSUM_EN
    rx_run("rx_hi", 1'b0, 8'd0, 64'h0);
`else
    rx_run("rx_hi", 1'b1, 8'd2, 64'h6948);
`endif

    rxq = '{8'h26, 8'h26, 8'h41, 8'h26, 8'h42, 8'h26, 8'h26};
`ifdef UART_FRAME_CHECKSUM_EN
    rx_run("rx_esc", 1'b0, 8'd0, 64'h0);
`else
    rx_run("rx_esc", 1'b1, 8'd3, 64'h422641);
`endif

    rxq = '{8'h55, 8'h26, 8'h55, 8'h26, 8'h26,
            8'h41, 8'h42, 8'h03, 8'h26, 8'h26};
`ifdef UART_FRAME_CHECKSUM_EN
    rx_run("rx_cs", 1'b1, 8'd2, 64'h4241);
`else
    rx_run("rx_cs", 1'b1, 8'd3, 64'h034241);
`endif

    rxq = '{8'h26, 8'h26, 8'h41, 8'h42, 8'h00, 8'h26, 8'h26};
`ifdef UART_FRAME_CHECKSUM_EN
    rx_run("rx_bad", 1'b0, 8'd0, 64'h0);
`else
    rx_run("rx_bad", 1'b1, 8'd3, 64'h004241);
`endif

    rxq = '{8'h26, 8'h26, 8'h31, 8'h32, 8'h33, 8'h34,
            8'h35, 8'h36, 8'h37, 8'h38};
    if (CS) rxq.push_back(8'h08);
    rxq.push_back(8'h26);
    rxq.push_back(8'h26);
    rx_run("rx_max", 1'b1, 8'd8, 64'h3837363534333231);

    rxq = '{8'h26, 8'h26};
    for (int i = 0; i < ML + 2; i++) rxq.push_back(8'h60 + 8'(i));
    rx_run("rx_ovf", 1'b0, 8'd0, 64'h0);

    e0 = n_rxe;
    rx_byte(8'h26);
    rx_byte(8'h26);
    rx_byte(8'h41);
    repeat (150) @(negedge sys_clk);
    chk("tmo_early_busy", rx_busy, 1'b1);
    chk("tmo_early_err", n_rxe - e0, 0);
    repeat (100) @(negedge sys_clk);
    chk("tmo_err", n_rxe - e0, 1);
    chk("tmo_busy", rx_busy, 1'b0);

    d0 = n_rxd;
    e0 = n_rxe;
    t0 = n_txd;
    rx_byte(8'h26);
    rx_byte(8'h26);
    rx_byte(8'h41);
    @(negedge sys_clk);
    tx_string = 64'h434241;
    tx_length = 8'd3;
    tx_req = 1'b1;
    @(negedge sys_clk);
    tx_req = 1'b0;
    repeat (25) @(negedge sys_clk);
    chk("mid_txbusy", tx_busy, 1'b1);
    chk("mid_rxbusy", rx_busy, 1'b1);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    chk("mrst_txbusy", tx_busy, 1'b0);
    chk("mrst_rxbusy", rx_busy, 1'b0);
    chk("mrst_btxdat", byte_tx_data, 8'h00);
    chk("mrst_rxlen", rx_length, 8'h00);
    chk("mrst_rxstr", rx_string, 64'h0);
    sys_rst_n = 1'b1;
    repeat (60) @(negedge sys_clk);
    chk("mrst_txdone", n_txd - t0, 0);
    chk("mrst_rxdone", n_rxd - d0, 0);
    chk("mrst_rxerr", n_rxe - e0, 0);
    chk("mrst_idle", tx_busy | rx_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
